// File: rtl/apb_read_arbiter_pkg.sv
// Shared types and constants for the APB constant-read arbiter.
// Holds the master FSM state type, slave word map and expected words.
package apb_const_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } apb_mst_st_t;

   localparam int unsigned ADDR_PI_HIGH = 0;
   localparam int unsigned ADDR_PI_LOW  = 1;
   localparam int unsigned ADDR_E_HIGH  = 2;
   localparam int unsigned ADDR_E_LOW   = 3;

   localparam logic [31:0] PI_HIGH = 32'hC90FDAA2;
   localparam logic [31:0] PI_LOW  = 32'h2168C234;
   localparam logic [31:0] E_HIGH  = 32'hADF85458;
   localparam logic [31:0] E_LOW   = 32'hA2BB4A9A;

endpackage

// File: rtl/apb_read_arbiter_if.sv
// APB read-only bus between the arbiter (master) and the constant slave.
// Write-side signals are absent: the slave is read-only.
interface apb_read_arbiter_if #(
   parameter int AW = 32
);

   logic          psel;
   logic          penable;
   logic [AW-1:0] paddr;
   logic [31:0]   prdata;
   logic          pready;
   logic          pslverr;

   modport master (
      output psel,
      output penable,
      output paddr,
      input  prdata,
      input  pready,
      input  pslverr
   );

   modport slave (
      input  psel,
      input  penable,
      input  paddr,
      output prdata,
      output pready,
      output pslverr
   );

endinterface

// File: rtl/apb_read_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or after rr_ptr.
// Returns the winner as one-hot, as an index, and a valid flag.
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int PW   = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [PW-1:0]   rr_ptr,
   output logic [NREQ-1:0] win_oh,
   output logic [PW-1:0]   win_idx,
   output logic            win_vld
);

   int idx;

   // Scan NREQ positions starting at rr_ptr, wrapping, first hit wins
   always_comb begin
      win_oh  = '0;
      win_idx = '0;
      win_vld = 1'b0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!win_vld && req[idx]) begin
            win_vld     = 1'b1;
            win_oh[idx] = 1'b1;
            win_idx     = PW'(idx);
         end
      end
   end

endmodule

// File: rtl/apb_read_arbiter.sv
// APB read master sharing one constant slave among NREQ requesters.
// Round-robin grant, SETUP/ACCESS sequencing, pready timeout abort.
module apb_read_arbiter
   import apb_const_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int AW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic             pclk,
   input  logic             preset,
   input  logic [NREQ-1:0]  req,
   input  logic [NREQ*AW-1:0] req_addr,
   output logic [NREQ-1:0]  gnt,
   output logic [NREQ-1:0]  rsp_valid,
   output logic [31:0]      rsp_data,
   output logic             rsp_err,
   apb_read_arbiter_if.master apb
);

   localparam int PW = $clog2(NREQ);
   localparam int CW = $clog2(TIMEOUT);

   apb_mst_st_t     state_q, state_d;
   logic [PW-1:0]   rr_q, rr_d;
   logic [PW-1:0]   owner_q, owner_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic [NREQ-1:0] rv_q, rv_d;
   logic [31:0]     data_q, data_d;
   logic            err_q, err_d;
   logic            psel_q, psel_d;
   logic            pen_q, pen_d;
   logic [AW-1:0]   paddr_q, paddr_d;

   logic [NREQ-1:0] win_oh;
   logic [PW-1:0]   win_idx;
   logic            win_vld;
   logic            tmo_hit;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .req     (req),
      .rr_ptr  (rr_q),
      .win_oh  (win_oh),
      .win_idx (win_idx),
      .win_vld (win_vld)
   );

   assign tmo_hit = !apb.pready && (cnt_q == CW'(TIMEOUT - 1));

   // State and all registered outputs; reset aborts any transfer
   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q <= IDLE;
         rr_q    <= '0;
         owner_q <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
         rv_q    <= '0;
         data_q  <= '0;
         err_q   <= 1'b0;
         psel_q  <= 1'b0;
         pen_q   <= 1'b0;
         paddr_q <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         rv_q    <= rv_d;
         data_q  <= data_d;
         err_q   <= err_d;
         psel_q  <= psel_d;
         pen_q   <= pen_d;
         paddr_q <= paddr_d;
      end
   end

   // Next-state: grant, one SETUP cycle, ACCESS until pready or timeout
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (win_vld) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  if (apb.pready || tmo_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output/datapath next values; pslverr only matters with pready
   always_comb begin
      rr_d    = rr_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      rv_d    = '0;
      data_d  = data_q;
      err_d   = err_q;
      psel_d  = psel_q;
      pen_d   = pen_q;
      paddr_d = paddr_q;
      unique case (state_q)
         IDLE: begin
            if (win_vld) begin
               gnt_d   = win_oh;
               paddr_d = req_addr[int'(win_idx)*AW +: AW];
               psel_d  = 1'b1;
               owner_d = win_idx;
               rr_d    = (win_idx == PW'(NREQ - 1)) ? '0
                                                    : win_idx + 1'b1;
            end
         end
         SETUP: begin
            pen_d = 1'b1;
            cnt_d = '0;
         end
         ACCESS: begin
            if (apb.pready) begin
               psel_d        = 1'b0;
               pen_d         = 1'b0;
               rv_d[owner_q] = 1'b1;
               data_d        = apb.prdata;
               err_d         = apb.pslverr;
            end else if (tmo_hit) begin
               psel_d        = 1'b0;
               pen_d         = 1'b0;
               rv_d[owner_q] = 1'b1;
               data_d        = '0;
               err_d         = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign gnt         = gnt_q;
   assign rsp_valid   = rv_q;
   assign rsp_data    = data_q;
   assign rsp_err     = err_q;
   assign apb.psel    = psel_q;
   assign apb.penable = pen_q;
   assign apb.paddr   = paddr_q;

endmodule

// File: tb/tb_apb_read_arbiter.sv
// Directed bench for apb_read_arbiter with a one-wait constant slave.
// Covers single read, sweep, contention, error, timeout and reset abort.
module tb_apb_read_arbiter;
   import apb_const_pkg::*;

   logic        pclk;
   logic        preset;
   logic [1:0]  req;
   logic [63:0] req_addr;
   logic [1:0]  gnt;
   logic [1:0]  rsp_valid;
   logic [31:0] rsp_data;
   logic        rsp_err;
   logic        hang;

   int checks;
   int errors;
   int n;
   int cnt;

   apb_read_arbiter_if #(.AW(32)) apb_bus ();

   apb_read_arbiter #(
      .NREQ    (2),
      .AW      (32),
      .TIMEOUT (16)
   ) dut (
      .pclk      (pclk),
      .preset    (preset),
      .req       (req),
      .req_addr  (req_addr),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .apb       (apb_bus)
   );

   initial pclk = 1'b0;
   always #5 pclk = ~pclk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      case (a)
         ADDR_PI_HIGH: rom = PI_HIGH;
         ADDR_PI_LOW:  rom = PI_LOW;
         ADDR_E_HIGH:  rom = E_HIGH;
         ADDR_E_LOW:   rom = E_LOW;
         default:      rom = 32'h0;
      endcase
   endfunction

   // One-wait slave with registered pready; hang holds pready low
   always @(posedge pclk) begin
      if (preset) begin
         apb_bus.pready  <= 1'b0;
         apb_bus.prdata  <= '0;
         apb_bus.pslverr <= 1'b0;
      end else if (apb_bus.psel && apb_bus.penable &&
                   !apb_bus.pready && !hang) begin
         apb_bus.pready  <= 1'b1;
         apb_bus.prdata  <= rom(apb_bus.paddr);
         apb_bus.pslverr <= (apb_bus.paddr > 32'd3);
      end else begin
         apb_bus.pready  <= 1'b0;
         apb_bus.prdata  <= '0;
         apb_bus.pslverr <= 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic wait_gnt(input logic [1:0] m, output int k);
      k = 0;
      while ((gnt & m) == 2'b00 && k < 30) begin
         step();
         k++;
      end
      chk("gnt_wait", 64'((gnt & m) != 2'b00), 64'd1);
   endtask

   task automatic wait_rsp(output int k);
      k = 0;
      while (rsp_valid == 2'b00 && k < 60) begin
         step();
         k++;
      end
      chk("rsp_wait", 64'(rsp_valid != 2'b00), 64'd1);
   endtask

   logic [31:0] sweep [3];
   logic [1:0]  order [4];

   initial begin
      checks   = 0;
      errors   = 0;
      preset   = 1'b1;
      req      = 2'b00;
      req_addr = '0;
      hang     = 1'b0;
      sweep[0] = 32'h2168C234;
      sweep[1] = 32'hADF85458;
      sweep[2] = 32'hA2BB4A9A;
      order[0] = 2'b01;
      order[1] = 2'b10;
      order[2] = 2'b01;
      order[3] = 2'b10;
      repeat (2) step();
      chk("rst_gnt", 64'(gnt), 64'd0);
      chk("rst_rv", 64'(rsp_valid), 64'd0);
      chk("rst_psel", 64'(apb_bus.psel), 64'd0);
      chk("rst_pen", 64'(apb_bus.penable), 64'd0);
      chk("rst_data", 64'(rsp_data), 64'd0);
      preset = 1'b0;
      step();

      // single read of word 0
      req_addr[31:0] = 32'd0;
      req = 2'b01;
      step();
      chk("t1_gnt", 64'(gnt), 64'h1);
      chk("t1_psel", 64'(apb_bus.psel), 64'd1);
      chk("t1_pen0", 64'(apb_bus.penable), 64'd0);
      chk("t1_paddr", 64'(apb_bus.paddr), 64'd0);
      req = 2'b00;
      step();
      chk("t1_pen1", 64'(apb_bus.penable), 64'd1);
      chk("t1_gnt0", 64'(gnt), 64'd0);
      wait_rsp(n);
      chk("t1_lat", 64'(n), 64'd2);
      chk("t1_rv", 64'(rsp_valid), 64'h1);
      chk("t1_data", 64'(rsp_data), 64'hC90FDAA2);
      chk("t1_err", 64'(rsp_err), 64'd0);
      step();
      chk("t1_pulse", 64'(rsp_valid), 64'd0);
      chk("t1_hold", 64'(rsp_data), 64'hC90FDAA2);

      // back-to-back sweep of words 1..3 from requester 1
      req_addr[63:32] = 32'd1;
      req = 2'b10;
      for (int k = 0; k < 3; k++) begin
         wait_gnt(2'b10, n);
         chk("t2_gnt", 64'(gnt), 64'h2);
         if (k < 2) req_addr[63:32] = 32'(k + 2);
         else req = 2'b00;
         wait_rsp(n);
         chk("t2_rv", 64'(rsp_valid), 64'h2);
         chk("t2_data", 64'(rsp_data), 64'(sweep[k]));
         chk("t2_gap", 64'(apb_bus.psel), 64'd0);
      end

      // contention from a fresh rr_ptr
      preset = 1'b1;
      step();
      preset = 1'b0;
      req_addr = {32'd3, 32'd2};
      req = 2'b11;
      for (int k = 0; k < 4; k++) begin
         wait_gnt(2'b11, n);
         chk("t3_gnt", 64'(gnt), 64'(order[k]));
         if (k == 3) req = 2'b00;
         wait_rsp(n);
         chk("t3_rv", 64'(rsp_valid), 64'(order[k]));
         chk("t3_data", 64'(rsp_data),
             (order[k] == 2'b01) ? 64'hADF85458 : 64'hA2BB4A9A);
      end

      // bad address then a good one
      req_addr[31:0] = 32'h4;
      req = 2'b01;
      wait_gnt(2'b01, n);
      req = 2'b00;
      wait_rsp(n);
      chk("t4_rv", 64'(rsp_valid), 64'h1);
      chk("t4_err", 64'(rsp_err), 64'd1);
      chk("t4_data", 64'(rsp_data), 64'd0);
      req_addr[31:0] = 32'h0;
      req = 2'b01;
      wait_gnt(2'b01, n);
      req = 2'b00;
      wait_rsp(n);
      chk("t4_err2", 64'(rsp_err), 64'd0);
      chk("t4_data2", 64'(rsp_data), 64'hC90FDAA2);

      // hung slave times out after 16 ACCESS cycles
      hang = 1'b1;
      req_addr[31:0] = 32'h1;
      req = 2'b01;
      wait_gnt(2'b01, n);
      req = 2'b00;
      cnt = 0;
      n = 0;
      while (rsp_valid == 2'b00 && n < 60) begin
         step();
         n++;
         if (rsp_valid == 2'b00 && apb_bus.penable) cnt++;
      end
      chk("t5_cycles", 64'(cnt), 64'd16);
      chk("t5_rv", 64'(rsp_valid), 64'h1);
      chk("t5_err", 64'(rsp_err), 64'd1);
      chk("t5_data", 64'(rsp_data), 64'd0);
      chk("t5_psel", 64'(apb_bus.psel), 64'd0);
      chk("t5_pen", 64'(apb_bus.penable), 64'd0);
      hang = 1'b0;
      step();

      // reset during ACCESS with the request still held
      req_addr[31:0] = 32'h2;
      req = 2'b01;
      wait_gnt(2'b01, n);
      step();
      chk("t6_pen", 64'(apb_bus.penable), 64'd1);
      preset = 1'b1;
      step();
      preset = 1'b0;
      chk("t6_gnt", 64'(gnt), 64'd0);
      chk("t6_rv", 64'(rsp_valid), 64'd0);
      chk("t6_err", 64'(rsp_err), 64'd0);
      chk("t6_psel", 64'(apb_bus.psel), 64'd0);
      chk("t6_pen0", 64'(apb_bus.penable), 64'd0);
      chk("t6_paddr", 64'(apb_bus.paddr), 64'd0);
      step();
      chk("t6_norv", 64'(rsp_valid), 64'd0);
      chk("t6_regnt", 64'(gnt), 64'h1);
      req = 2'b00;
      wait_rsp(n);
      chk("t6_rv2", 64'(rsp_valid), 64'h1);
      chk("t6_data", 64'(rsp_data), 64'hADF85458);
      chk("t6_err2", 64'(rsp_err), 64'd0);

      step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
